// File: rtl/mips_main_ctrl.sv
// Main control decoder for the single-issue MIPS CPU: primary opcode to registered
// datapath strobes, with synchronous active-low reset and a pipeline-bubble flush.
module mips_main_ctrl (
  input  logic       clk,
  input  logic       rstN,
  input  logic       flush,
  input  logic [5:0] opCode,
  output logic       regDst,
  output logic       aluSrc,
  output logic       memToReg,
  output logic       regWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       branch,
  output logic [1:0] aluop,
  output logic       jmp,
  output logic       illegalOp
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   reg_dst;
    logic   alu_src;
    logic   mem_to_reg;
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   branch;
    aluop_e aluop;
    logic   jmp;
    logic   illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  ctrl_t decode_w;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Unlisted opcodes, including any with X/Z bits, fall to the default arm and
  // flag illegalOp without touching registers or memory.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    decode_w = CTRL_NOP;
    case (opCode)
      OP_RTYPE: begin
        decode_w.reg_dst   = 1'b1;
        decode_w.reg_write = 1'b1;
        decode_w.aluop     = ALUOP_FUNCT;
      end
      OP_LW: begin
        decode_w.alu_src    = 1'b1;
        decode_w.mem_to_reg = 1'b1;
        decode_w.reg_write  = 1'b1;
        decode_w.mem_read   = 1'b1;
      end
      OP_SW: begin
        decode_w.alu_src   = 1'b1;
        decode_w.mem_write = 1'b1;
      end
      OP_BEQ: begin
        decode_w.branch = 1'b1;
        decode_w.aluop  = ALUOP_SUB;
      end
      OP_ADDI: begin
        decode_w.alu_src   = 1'b1;
        decode_w.reg_write = 1'b1;
      end
      OP_J: begin
        decode_w.jmp = 1'b1;
      end
      default: begin
        decode_w.illegal_op = 1'b1;
      end
    endcase
  end

  assign ctrl_d = flush ? CTRL_NOP : decode_w;

  // Reset takes priority over flush; both load the NOP word.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rstN) ctrl_q <= CTRL_NOP;
    else       ctrl_q <= ctrl_d;
  end

  assign regDst    = ctrl_q.reg_dst;
  assign aluSrc    = ctrl_q.alu_src;
  assign memToReg  = ctrl_q.mem_to_reg;
  assign regWrite  = ctrl_q.reg_write;
  assign memRead   = ctrl_q.mem_read;
  assign memWrite  = ctrl_q.mem_write;
  assign branch    = ctrl_q.branch;
  assign aluop     = ctrl_q.aluop;
  assign jmp       = ctrl_q.jmp;
  assign illegalOp = ctrl_q.illegal_op;

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Scoreboard bench for mips_main_ctrl: the driver queues the expected control word
// per edge, a monitor pops and compares it just after each rising edge.
module tb_mips_main_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       flush;
  logic [5:0] opCode;
  logic       regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, jmp, illegalOp;
  logic [1:0] aluop;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected word order: regDst aluSrc memToReg regWrite memRead memWrite branch aluop[1:0] jmp illegalOp
  logic [10:0] exp_q[$];
  string       name_q[$];

  mips_main_ctrl dut (
    .clk      (clk),
    .rstN     (rstN),
    .flush    (flush),
    .opCode   (opCode),
    .regDst   (regDst),
    .aluSrc   (aluSrc),
    .memToReg (memToReg),
    .regWrite (regWrite),
    .memRead  (memRead),
    .memWrite (memWrite),
    .branch   (branch),
    .aluop    (aluop),
    .jmp      (jmp),
    .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: each strobe is derived from which instruction class is present.
  function automatic logic [10:0] model(input logic rst_n, input logic fl, input logic [5:0] op);
    logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, known;
    logic [1:0] aop;
    if (!rst_n || fl) return '0;
    is_r    = (op === 6'd0);
    is_j    = (op === 6'd2);
    is_beq  = (op === 6'd4);
    is_addi = (op === 6'd8);
    is_lw   = (op === 6'd35);
    is_sw   = (op === 6'd43);
    known   = is_r | is_j | is_beq | is_addi | is_lw | is_sw;
    aop     = is_r ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
    return {is_r, is_lw | is_sw | is_addi, is_lw, is_r | is_lw | is_addi,
            is_lw, is_sw, is_beq, aop, is_j, ~known};
  endfunction

  // Present inputs for the next rising edge and queue the word that edge must load.
  task automatic apply(input string name, input logic rst_n, input logic fl, input logic [5:0] op);
    rstN   = rst_n;
    flush  = fl;
    opCode = op;
    exp_q.push_back(model(rst_n, fl, op));
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // Monitor: one registered word per rising edge.
  initial begin
    logic [10:0] act;
    logic [10:0] exp;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluop, jmp, illegalOp};
        check(nm, act, exp);
        check({nm, "_mem_excl"}, {10'd0, memRead & memWrite}, 11'd0);
        check({nm, "_jmp_excl"}, {10'd0, jmp & (branch | regWrite)}, 11'd0);
      end
    end
  end

  initial begin
    logic [5:0] listed[6];
    int wait_cycles;
    listed[0] = 6'b000000; listed[1] = 6'b100011; listed[2] = 6'b101011;
    listed[3] = 6'b000100; listed[4] = 6'b001000; listed[5] = 6'b000010;

    apply("reset0", 1'b0, 1'b0, 6'b000000);
    apply("reset1", 1'b0, 1'b0, 6'b000000);
    apply("rtype",  1'b1, 1'b0, 6'b000000);
    apply("j",      1'b1, 1'b0, 6'b000010);
    apply("illegal_110000", 1'b1, 1'b0, 6'b110000);
    apply("lw",     1'b1, 1'b0, 6'b100011);
    apply("sw",     1'b1, 1'b0, 6'b101011);
    apply("beq",    1'b1, 1'b0, 6'b000100);
    apply("addi",   1'b1, 1'b0, 6'b001000);
    apply("lw_flush",     1'b1, 1'b1, 6'b100011);
    apply("lw_again",     1'b1, 1'b0, 6'b100011);
    apply("flush_and_rst", 1'b0, 1'b1, 6'b100011);
    apply("illegal_after_rst", 1'b1, 1'b0, 6'b111111);
    apply("illegal_000001",    1'b1, 1'b0, 6'b000001);
    apply("rst_with_illegal",  1'b0, 1'b0, 6'b111111);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic fl, rn;
      op = ($urandom_range(0, 1) == 0) ? listed[$urandom_range(0, 5)] : 6'($urandom());
      fl = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 19) != 0);
      apply($sformatf("rand%0d_op%b", i, op), rn, fl, op);
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
